// File: rtl/ddr_app_responder.sv
// ddr_app_responder
//   Stands in for the DDR controller on the application side of the traffic
//   generator. Write beats are staged until the write address arrives, then
//   committed to an internal word memory one word per cycle. Each read
//   address is answered with a fixed-length burst after a fixed latency. One
//   read request can be active and one more can wait in a pending register.
//
// Ports
//   app_clk            sole clock
//   rst_n              synchronous active-low reset
//   app_data_wr        write data beat
//   app_data_wr_valid  write data beat valid
//   app_addr_wr        write burst start byte address
//   app_addr_wr_valid  write address valid; closes the staged burst
//   app_addr_rd        read burst start byte address
//   app_addr_rd_valid  read address valid
//   app_data_rd        read data beat (holds its value while not valid)
//   app_data_rd_valid  read data beat valid
//   busy               commit or read request in progress
//   err_wr_overflow    sticky: a write beat was dropped
//   err_rd_overflow    sticky: a read request was dropped
//   wr_commit_cnt      committed write bursts (wraps)
//   rd_burst_cnt       completed read bursts (wraps)
module ddr_app_responder #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int WR_NUM     = 32,
  parameter int RD_NUM     = 32,
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic                  app_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] app_data_wr,
  input  logic                  app_data_wr_valid,
  input  logic [ADDR_WIDTH-1:0] app_addr_wr,
  input  logic                  app_addr_wr_valid,
  input  logic [ADDR_WIDTH-1:0] app_addr_rd,
  input  logic                  app_addr_rd_valid,
  output logic [DATA_WIDTH-1:0] app_data_rd,
  output logic                  app_data_rd_valid,
  output logic                  busy,
  output logic                  err_wr_overflow,
  output logic                  err_rd_overflow,
  output logic [31:0]           wr_commit_cnt,
  output logic [31:0]           rd_burst_cnt
);

  localparam int KW = $clog2(WR_NUM + 1);                          // beat count 0..WR_NUM
  localparam int SW = (WR_NUM > 1) ? $clog2(WR_NUM) : 1;           // staging index
  localparam int BW = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;           // read beat index
  localparam int LW = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1; // wait counter

  typedef enum logic {WR_COLLECT, WR_COMMIT} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;

  logic [DATA_WIDTH-1:0] mem     [2**MEM_AW];
  logic [DATA_WIDTH-1:0] staging [WR_NUM];

  // Only the word-index bits of the byte addresses are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{app_addr_wr, app_addr_rd};

  // ---------------------------------------------------------------- write side
  wr_state_t         wr_state;
  logic [KW-1:0]     wr_k;         // beats staged so far
  logic [KW-1:0]     commit_len;
  logic [KW-1:0]     commit_idx;
  logic [MEM_AW-1:0] commit_base;
  logic              beat_ok;
  logic [KW-1:0]     k_eff;        // staged count including this cycle's beat
  logic [MEM_AW-1:0] mem_waddr;

  assign beat_ok   = (wr_state == WR_COLLECT) && app_data_wr_valid && (wr_k < KW'(WR_NUM));
  assign k_eff     = wr_k + KW'(beat_ok);
  assign mem_waddr = commit_base + MEM_AW'(commit_idx);  // wraps modulo memory depth

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge app_clk) begin
    if (!rst_n) begin
      wr_state        <= WR_COLLECT;
      wr_k            <= '0;
      commit_len      <= '0;
      commit_idx      <= '0;
      commit_base     <= '0;
      err_wr_overflow <= 1'b0;
      wr_commit_cnt   <= '0;
    end else begin
      // A beat offered while full or while committing is lost.
      if (app_data_wr_valid && !beat_ok) err_wr_overflow <= 1'b1;

      case (wr_state)
        WR_COLLECT: begin
          if (app_addr_wr_valid && (k_eff != '0)) begin
            commit_base   <= app_addr_wr[MEM_AW+1:2];
            commit_len    <= k_eff;
            commit_idx    <= '0;
            wr_k          <= '0;
            wr_commit_cnt <= wr_commit_cnt + 32'd1;
            wr_state      <= WR_COMMIT;
          end else begin
            wr_k <= k_eff;   // an address with nothing staged is a no-op
          end
        end
        WR_COMMIT: begin
          commit_idx <= commit_idx + KW'(1);
          if (commit_idx == commit_len - KW'(1)) wr_state <= WR_COLLECT;
        end
        default: wr_state <= WR_COLLECT;
      endcase
    end
  end

  // NOTE: the staging buffer and word memory carry no reset; their contents
  // are only meaningful once written, and a reset would block RAM inference.
  always_ff @(posedge app_clk) begin
    if (beat_ok) staging[wr_k[SW-1:0]] <= app_data_wr;
    if (rst_n && (wr_state == WR_COMMIT)) mem[mem_waddr] <= staging[commit_idx[SW-1:0]];
  end

  // ----------------------------------------------------------------- read side
  rd_state_t         rd_state;
  logic [LW-1:0]     wait_cnt;
  logic [BW-1:0]     rd_beat;      // beat currently on app_data_rd
  logic [MEM_AW-1:0] rd_base;
  logic [MEM_AW-1:0] pend_base;
  logic              pend_valid;
  logic [MEM_AW-1:0] req_base;
  logic              rd_last;
  logic              rd_issue;     // memory read this cycle, data valid next cycle
  logic [MEM_AW-1:0] rd_raddr;
  logic              req_to_pend;
  logic              req_drop;

  assign req_base    = app_addr_rd[MEM_AW+1:2];
  assign rd_last     = (rd_state == RD_BURST) && (rd_beat == BW'(RD_NUM - 1));
  assign req_drop    = app_addr_rd_valid && (rd_state != RD_IDLE) && pend_valid;
  // At the last beat with nothing pending, a new request restarts WAIT directly.
  assign req_to_pend = app_addr_rd_valid && (rd_state != RD_IDLE) && !pend_valid && !rd_last;

  // Reads are issued one cycle ahead of the beat they produce. On the last
  // beat the pending request's first word is fetched so its burst follows
  // without a gap.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_issue = 1'b0;
    rd_raddr = rd_base;
    case (rd_state)
      RD_WAIT:  rd_issue = (wait_cnt == LW'(RD_LATENCY - 2));
      RD_BURST: begin
        if (!rd_last) begin
          rd_issue = 1'b1;
          rd_raddr = rd_base + MEM_AW'(rd_beat) + MEM_AW'(1);
        end else if (pend_valid) begin
          rd_issue = 1'b1;
          rd_raddr = pend_base;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge app_clk) begin
    if (!rst_n) begin
      rd_state          <= RD_IDLE;
      wait_cnt          <= '0;
      rd_beat           <= '0;
      rd_base           <= '0;
      pend_base         <= '0;
      pend_valid        <= 1'b0;
      err_rd_overflow   <= 1'b0;
      rd_burst_cnt      <= '0;
      app_data_rd_valid <= 1'b0;
      app_data_rd       <= '0;
    end else begin
      app_data_rd_valid <= rd_issue;
      if (rd_issue) app_data_rd <= mem[rd_raddr];   // old data on a same-cycle write

      if (req_drop) err_rd_overflow <= 1'b1;
      if (req_to_pend) begin
        pend_valid <= 1'b1;
        pend_base  <= req_base;
      end

      case (rd_state)
        RD_IDLE: begin
          if (app_addr_rd_valid) begin
            rd_base  <= req_base;
            wait_cnt <= '0;
            rd_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == LW'(RD_LATENCY - 2)) begin
            rd_beat  <= '0;
            rd_state <= RD_BURST;
          end else begin
            wait_cnt <= wait_cnt + LW'(1);
          end
        end
        RD_BURST: begin
          if (rd_last) begin
            rd_burst_cnt <= rd_burst_cnt + 32'd1;
            if (pend_valid) begin
              rd_base    <= pend_base;
              rd_beat    <= '0;
              pend_valid <= 1'b0;
            end else if (app_addr_rd_valid) begin
              rd_base  <= req_base;
              wait_cnt <= '0;
              rd_state <= RD_WAIT;
            end else begin
              rd_state <= RD_IDLE;
            end
          end else begin
            rd_beat <= rd_beat + BW'(1);
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign busy = (wr_state == WR_COMMIT) || (rd_state != RD_IDLE);

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed testbench for ddr_app_responder with default parameters.
module tb_ddr_app_responder;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          app_clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] app_data_wr;
  logic          app_data_wr_valid;
  logic [AW-1:0] app_addr_wr;
  logic          app_addr_wr_valid;
  logic [AW-1:0] app_addr_rd;
  logic          app_addr_rd_valid;
  logic [DW-1:0] app_data_rd;
  logic          app_data_rd_valid;
  logic          busy;
  logic          err_wr_overflow;
  logic          err_rd_overflow;
  logic [31:0]   wr_commit_cnt;
  logic [31:0]   rd_burst_cnt;

  ddr_app_responder dut (
    .app_clk           (app_clk),
    .rst_n             (rst_n),
    .app_data_wr       (app_data_wr),
    .app_data_wr_valid (app_data_wr_valid),
    .app_addr_wr       (app_addr_wr),
    .app_addr_wr_valid (app_addr_wr_valid),
    .app_addr_rd       (app_addr_rd),
    .app_addr_rd_valid (app_addr_rd_valid),
    .app_data_rd       (app_data_rd),
    .app_data_rd_valid (app_data_rd_valid),
    .busy              (busy),
    .err_wr_overflow   (err_wr_overflow),
    .err_rd_overflow   (err_rd_overflow),
    .wr_commit_cnt     (wr_commit_cnt),
    .rd_burst_cnt      (rd_burst_cnt)
  );

  always #5 app_clk = ~app_clk;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_commits = 0;
  int exp_bursts  = 0;

  logic [31:0] rd_buf [32];
  int rd_lat;
  int rd_n;

  // Stimulus helpers: inputs change on the falling edge, outputs are sampled there too.
  task automatic send_beats(input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      app_data_wr       = first + 32'(i);
      app_data_wr_valid = 1'b1;
      @(negedge app_clk);
    end
    app_data_wr_valid = 1'b0;
  endtask

  task automatic send_wr_addr(input logic [AW-1:0] a);
    app_addr_wr       = a;
    app_addr_wr_valid = 1'b1;
    @(negedge app_clk);
    app_addr_wr_valid = 1'b0;
  endtask

  // Issues one read and captures its burst; rd_lat is the cycle offset of the
  // first valid beat, rd_n the number of contiguous valid beats.
  task automatic read_burst(input logic [AW-1:0] a);
    bit started = 1'b0;
    rd_lat = -1;
    rd_n   = 0;
    for (int i = 0; i < 32; i++) rd_buf[i] = '0;
    app_addr_rd       = a;
    app_addr_rd_valid = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge app_clk);
      if (c == 1) app_addr_rd_valid = 1'b0;
      if (app_data_rd_valid) begin
        if (!started) begin
          started = 1'b1;
          rd_lat  = c;
        end
        if (rd_n < 32) rd_buf[rd_n] = app_data_rd;
        rd_n++;
      end else if (started) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    app_data_wr = '0; app_data_wr_valid = 1'b0;
    app_addr_wr = '0; app_addr_wr_valid = 1'b0;
    app_addr_rd = '0; app_addr_rd_valid = 1'b0;
    repeat (3) @(negedge app_clk);
    check_cnt++;
    if ({app_data_rd, app_data_rd_valid, busy, err_wr_overflow, err_rd_overflow,
         wr_commit_cnt, rd_burst_cnt} !== '0)
      $display("FAIL reset_outputs: data=%h v=%b busy=%b ew=%b er=%b wc=%0d rc=%0d, all must be 0",
               app_data_rd, app_data_rd_valid, busy, err_wr_overflow, err_rd_overflow,
               wr_commit_cnt, rd_burst_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge app_clk);
    check_cnt++;
    if (busy !== 1'b0 || app_data_rd_valid !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, app_data_rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    send_beats(32, 32'd1);
    send_wr_addr(30'h80);                 // now in cycle T+1
    exp_commits++;
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_first: busy=%b expected 1", busy);
    else pass_cnt++;
    repeat (31) @(negedge app_clk);       // T+32, last commit cycle
    check_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_last: busy=%b expected 1", busy);
    else pass_cnt++;
    @(negedge app_clk);                   // T+33, earliest read that sees all data
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end: busy=%b expected 0", busy);
    else pass_cnt++;
    check_cnt++;
    if (wr_commit_cnt !== 32'(exp_commits))
      $display("FAIL basic_commit_cnt: got %0d expected %0d", wr_commit_cnt, exp_commits);
    else pass_cnt++;
    read_burst(30'h80);
    exp_bursts++;
    check_cnt++;
    if (rd_lat !== 4) $display("FAIL basic_latency: got %0d expected 4", rd_lat);
    else pass_cnt++;
    check_cnt++;
    if (rd_n !== 32) $display("FAIL basic_beats: got %0d expected 32", rd_n);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(i + 1))
        $display("FAIL basic_data[%0d]: got %0d expected %0d", i, rd_buf[i], i + 1);
      else pass_cnt++;
    end
    check_cnt++;
    if (rd_burst_cnt !== 32'(exp_bursts))
      $display("FAIL basic_burst_cnt: got %0d expected %0d", rd_burst_cnt, exp_bursts);
    else pass_cnt++;
    check_cnt++;
    if (app_data_rd !== 32'd32)
      $display("FAIL basic_data_hold: got %0d expected 32", app_data_rd);
    else pass_cnt++;
  endtask

  task automatic test_commit_drop();
    // An address with nothing staged starts no commit.
    send_wr_addr(30'h700);
    check_cnt++;
    if (busy !== 1'b0 || wr_commit_cnt !== 32'(exp_commits))
      $display("FAIL empty_addr_noop: busy=%b cnt=%0d, expected 0 %0d", busy, wr_commit_cnt, exp_commits);
    else pass_cnt++;
    send_beats(3, 32'd301);
    app_data_wr = 32'd304; app_data_wr_valid = 1'b1;   // coincident with address
    app_addr_wr = 30'h400; app_addr_wr_valid = 1'b1;
    @(negedge app_clk);                                  // T+1, in COMMIT
    exp_commits++;
    app_addr_wr_valid = 1'b0;
    app_data_wr = 32'd999;                               // dropped
    check_cnt++;
    if (err_wr_overflow !== 1'b0)
      $display("FAIL coincident_beat_no_err: err=%b expected 0", err_wr_overflow);
    else pass_cnt++;
    @(negedge app_clk);
    app_data_wr_valid = 1'b0;
    check_cnt++;
    if (err_wr_overflow !== 1'b1)
      $display("FAIL commit_beat_err: err=%b expected 1", err_wr_overflow);
    else pass_cnt++;
    check_cnt++;
    if (wr_commit_cnt !== 32'(exp_commits))
      $display("FAIL commit_cnt2: got %0d expected %0d", wr_commit_cnt, exp_commits);
    else pass_cnt++;
    repeat (5) @(negedge app_clk);
    read_burst(30'h400);
    exp_bursts++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(301 + i))
        $display("FAIL commit_data[%0d]: got %0d expected %0d", i, rd_buf[i], 301 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_wr_overflow();
    // Clear the sticky flag from the previous scenario.
    rst_n = 1'b0;
    @(negedge app_clk);
    rst_n = 1'b1;
    exp_commits = 0;
    exp_bursts  = 0;
    @(negedge app_clk);
    send_beats(32, 32'd101);
    check_cnt++;
    if (err_wr_overflow !== 1'b0) $display("FAIL full_no_err: err=%b expected 0", err_wr_overflow);
    else pass_cnt++;
    send_beats(1, 32'd133);
    check_cnt++;
    if (err_wr_overflow !== 1'b1) $display("FAIL overflow_err: err=%b expected 1", err_wr_overflow);
    else pass_cnt++;
    send_wr_addr(30'h200);
    exp_commits++;
    repeat (40) @(negedge app_clk);
    read_burst(30'h200);
    exp_bursts++;
    check_cnt++;
    if (rd_n !== 32) $display("FAIL overflow_beats: got %0d expected 32", rd_n);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(101 + i))
        $display("FAIL overflow_data[%0d]: got %0d expected %0d", i, rd_buf[i], 101 + i);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    send_beats(32, 32'd201);
    send_wr_addr(30'hFC0);
    exp_commits++;
    repeat (40) @(negedge app_clk);
    read_burst(30'hFC0);
    exp_bursts++;
    for (int i = 0; i < 32; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(201 + i))
        $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, rd_buf[i], 201 + i);
      else pass_cnt++;
    end
    read_burst(30'h000);
    exp_bursts++;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(217 + i))
        $display("FAIL wrap_low[%0d]: got %0d expected %0d", i, rd_buf[i], 217 + i);
      else pass_cnt++;
    end
    check_cnt++;
    if (wr_commit_cnt !== 32'(exp_commits))
      $display("FAIL wrap_commit_cnt: got %0d expected %0d", wr_commit_cnt, exp_commits);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic        vld [1:80];
    logic [31:0] dat [1:80];
    int first_c = -1;
    int last_c  = -1;
    int n_vld   = 0;
    // Reference data at 0x200: beats 101..132.
    check_cnt++;
    if (err_rd_overflow !== 1'b0) $display("FAIL b2b_err_before: err=%b expected 0", err_rd_overflow);
    else pass_cnt++;
    app_addr_rd = 30'h200;
    app_addr_rd_valid = 1'b1;          // requests in T, T+1, T+2
    for (int c = 1; c <= 80; c++) begin
      @(negedge app_clk);
      if (c == 3) app_addr_rd_valid = 1'b0;
      if (c == 2) begin
        check_cnt++;
        if (err_rd_overflow !== 1'b0)
          $display("FAIL b2b_pending_no_err: err=%b expected 0", err_rd_overflow);
        else pass_cnt++;
      end
      if (c == 3) begin
        check_cnt++;
        if (err_rd_overflow !== 1'b1)
          $display("FAIL b2b_drop_err: err=%b expected 1", err_rd_overflow);
        else pass_cnt++;
      end
      vld[c] = app_data_rd_valid;
      dat[c] = app_data_rd;
    end
    exp_bursts += 2;
    for (int c = 1; c <= 80; c++) begin
      if (vld[c] === 1'b1) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_vld++;
      end
    end
    check_cnt++;
    if (first_c !== 4) $display("FAIL b2b_first: got %0d expected 4", first_c);
    else pass_cnt++;
    check_cnt++;
    if (last_c !== 67) $display("FAIL b2b_last: got %0d expected 67", last_c);
    else pass_cnt++;
    check_cnt++;
    if (n_vld !== 64) $display("FAIL b2b_count: got %0d expected 64", n_vld);
    else pass_cnt++;
    for (int c = 4; c <= 67; c++) begin
      check_cnt++;
      if (dat[c] !== 32'(101 + ((c - 4) % 32)))
        $display("FAIL b2b_data[%0d]: got %0d expected %0d", c, dat[c], 101 + ((c - 4) % 32));
      else pass_cnt++;
    end
    check_cnt++;
    if (rd_burst_cnt !== 32'(exp_bursts))
      $display("FAIL b2b_burst_cnt: got %0d expected %0d", rd_burst_cnt, exp_bursts);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    app_addr_rd = 30'h200;
    app_addr_rd_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge app_clk);
      if (c == 1) app_addr_rd_valid = 1'b0;
    end
    // Cycle T+13 carries the 10th beat.
    check_cnt++;
    if (app_data_rd_valid !== 1'b1 || app_data_rd !== 32'd110)
      $display("FAIL mid_beat10: valid=%b data=%0d expected 1 110", app_data_rd_valid, app_data_rd);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge app_clk);
    rst_n = 1'b1;
    exp_commits = 0;
    exp_bursts  = 0;
    check_cnt++;
    if ({app_data_rd, app_data_rd_valid, busy, err_wr_overflow, err_rd_overflow,
         wr_commit_cnt, rd_burst_cnt} !== '0)
      $display("FAIL mid_reset_outputs: data=%h v=%b busy=%b ew=%b er=%b wc=%0d rc=%0d, all must be 0",
               app_data_rd, app_data_rd_valid, busy, err_wr_overflow, err_rd_overflow,
               wr_commit_cnt, rd_burst_cnt);
    else pass_cnt++;
    repeat (2) @(negedge app_clk);
    read_burst(30'h200);
    exp_bursts++;
    check_cnt++;
    if (rd_lat !== 4 || rd_n !== 32)
      $display("FAIL post_reset_timing: lat=%0d beats=%0d expected 4 32", rd_lat, rd_n);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      check_cnt++;
      if (rd_buf[i] !== 32'(101 + i))
        $display("FAIL post_reset_data[%0d]: got %0d expected %0d", i, rd_buf[i], 101 + i);
      else pass_cnt++;
    end
    check_cnt++;
    if (rd_burst_cnt !== 32'(exp_bursts) || wr_commit_cnt !== 32'(exp_commits))
      $display("FAIL post_reset_cnts: rd=%0d wr=%0d expected %0d %0d",
               rd_burst_cnt, wr_commit_cnt, exp_bursts, exp_commits);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, check_cnt);
    $fatal(1);
  end

  initial begin
    @(negedge app_clk);
    test_reset();
    test_basic();
    test_commit_drop();
    test_wr_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
